// File: rtl/trace_buffer.sv
// Multi-channel trace capture buffer with arm/trigger/post-trigger window.
// Captures into a register ring, then reads out oldest-first on request.
module trace_buffer #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int DEPTH    = 16,
  localparam int AW      = $clog2(DEPTH),
  localparam int DW      = CHANNELS * WIDTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] ch_data,
  input  logic          sample_en,
  input  logic          trig_in,
  input  logic          arm,
  input  logic          abort,
  input  logic [AW:0]   post_len,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic [1:0]    state,
  output logic          done,
  output logic [AW:0]   count,
  output logic [AW:0]   rd_left,
  output logic [AW-1:0] trig_pos,
  output logic          wrapped
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [AW:0]   FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   MAXP  = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0]   ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_P = AW'(1);

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [AW:0]     post_q, post_d;
  logic [AW:0]     rem_q, rem_d;
  logic [AW:0]     rd_left_q, rd_left_d;
  logic [AW-1:0]   trig_pos_q, trig_pos_d;
  logic            wrapped_q, wrapped_d;
  logic            done_q, done_d;
  logic            rd_valid_q, rd_valid_d;
  logic [DW-1:0]   rd_data_q, rd_data_d;
  logic            we;
  logic [DW-1:0]   mem_q [DEPTH];

  // Next-state logic: abort wins, then per-state capture/readout rules.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    post_d     = post_q;
    rem_d      = rem_q;
    rd_left_d  = rd_left_q;
    trig_pos_d = trig_pos_q;
    wrapped_d  = wrapped_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    we         = 1'b0;
    if (abort) begin
      state_d   = IDLE;
      rd_left_d = '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (arm) begin
            state_d   = ARMED;
            wr_ptr_d  = '0;
            count_d   = '0;
            wrapped_d = 1'b0;
            rd_left_d = '0;
            post_d    = (post_len > MAXP) ? MAXP : post_len;
          end else if (state_q == DONE && rd_en && rd_left_q != '0) begin
            rd_valid_d = 1'b1;
            rd_data_d  = mem_q[rd_ptr_q];
            rd_ptr_d   = rd_ptr_q + ONE_P;
            rd_left_d  = rd_left_q - ONE;
          end
        end
        ARMED, POST: begin
          if (sample_en) begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + ONE_P;
            // Ring is full once count saturates: next write overwrites.
            if (count_q == FULL) wrapped_d = 1'b1;
            else count_d = count_q + ONE;
            if (state_q == ARMED) begin
              if (trig_in) begin
                if (post_q == '0) state_d = DONE;
                else begin
                  state_d = POST;
                  rem_d   = post_q;
                end
              end
            end else begin
              rem_d = rem_q - ONE;
              if (rem_q == ONE) state_d = DONE;
            end
            if (state_d == DONE) begin
              rd_left_d  = count_d;
              rd_ptr_d   = (count_d == FULL) ? wr_ptr_d : '0;
              trig_pos_d = AW'(count_d - ONE - post_q);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    done_d = (state_d == DONE);
  end

  // Control and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      post_q     <= '0;
      rem_q      <= '0;
      rd_left_q  <= '0;
      trig_pos_q <= '0;
      wrapped_q  <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      post_q     <= post_d;
      rem_q      <= rem_d;
      rd_left_q  <= rd_left_d;
      trig_pos_q <= trig_pos_d;
      wrapped_q  <= wrapped_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Sample storage; contents are never visible before a capture completes.
  always_ff @(posedge clk) begin
    if (we) mem_q[wr_ptr_q] <= ch_data;
  end

  assign state    = state_q;
  assign done     = done_q;
  assign count    = count_q;
  assign rd_left  = rd_left_q;
  assign trig_pos = trig_pos_q;
  assign wrapped  = wrapped_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_trace_buffer.sv
// Bench for trace_buffer: queue-based capture model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_trace_buffer;

  localparam int W  = 16;
  localparam int CH = 2;
  localparam int D  = 8;
  localparam int AW = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [CH*W-1:0] ch_data = '0;
  logic            sample_en = 1'b0;
  logic            trig_in = 1'b0;
  logic            arm = 1'b0;
  logic            abort = 1'b0;
  logic [AW:0]     post_len = '0;
  logic            rd_en = 1'b0;
  logic [CH*W-1:0] rd_data;
  logic            rd_valid;
  logic [1:0]      state;
  logic            done;
  logic [AW:0]     count;
  logic [AW:0]     rd_left;
  logic [AW-1:0]   trig_pos;
  logic            wrapped;

  trace_buffer #(.WIDTH(W), .CHANNELS(CH), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .ch_data(ch_data),
    .sample_en(sample_en), .trig_in(trig_in), .arm(arm),
    .abort(abort), .post_len(post_len), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .state(state),
    .done(done), .count(count), .rd_left(rd_left),
    .trig_pos(trig_pos), .wrapped(wrapped)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  function automatic logic [31:0] mk(int k);
    return {16'(k + 256), 16'(k)};
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: log of every sample since arm, readout queue built at done.
  int          m_state = 0;
  int          m_log[$];
  int          m_rdq[$];
  int          m_post = 0;
  int          m_rem = 0;
  int          m_tp = 0;
  logic        m_valid = 1'b0;
  logic [31:0] m_data = '0;
  int          cur_k = 0;

  function automatic int mcount();
    return (m_log.size() > D) ? D : m_log.size();
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_log.delete();
    m_rdq.delete();
    m_tp = 0;
    m_valid = 1'b0;
    m_data = '0;
  endtask

  task automatic model_finish();
    int n;
    n = mcount();
    m_state = 3;
    m_rdq.delete();
    for (int i = m_log.size() - n; i < m_log.size(); i++)
      m_rdq.push_back(m_log[i]);
    m_tp = n - 1 - m_post;
  endtask

  task automatic model_start();
    m_state = 1;
    m_log.delete();
    m_rdq.delete();
    m_post = (int'(post_len) > D - 1) ? D - 1 : int'(post_len);
  endtask

  task automatic model_step();
    if (reset) model_reset();
    else begin
      m_valid = 1'b0;
      if (abort) begin
        m_state = 0;
        m_rdq.delete();
      end else begin
        case (m_state)
          0: if (arm) model_start();
          1: if (sample_en) begin
            m_log.push_back(cur_k);
            if (trig_in) begin
              if (m_post == 0) model_finish();
              else begin
                m_state = 2;
                m_rem = m_post;
              end
            end
          end
          2: if (sample_en) begin
            m_log.push_back(cur_k);
            m_rem--;
            if (m_rem == 0) model_finish();
          end
          default: begin
            if (arm) model_start();
            else if (rd_en && m_rdq.size() > 0) begin
              m_valid = 1'b1;
              m_data = mk(m_rdq.pop_front());
            end
          end
        endcase
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic samp(int k, logic t);
    cur_k = k;
    ch_data = mk(k);
    sample_en = 1'b1;
    trig_in = t;
    tick();
    sample_en = 1'b0;
    trig_in = 1'b0;
  endtask

  task automatic do_arm(int pl);
    arm = 1'b1;
    post_len = (AW+1)'(pl);
    tick();
    arm = 1'b0;
  endtask

  task automatic rd();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("m_state", state, m_state);
      chk("m_done", done, m_state == 3);
      chk("m_count", count, mcount());
      chk("m_wrapped", wrapped, m_log.size() > D);
      chk("m_rd_left", rd_left, m_rdq.size());
      chk("m_trig_pos", trig_pos, m_tp);
      chk("m_rd_valid", rd_valid, m_valid);
      chk("m_rd_data", rd_data, m_data);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    model_reset();
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("rst_state", state, 0);
    chk("rst_count", count, 0);
    chk("rst_valid", rd_valid, 0);
    chk("rst_data", rd_data, 0);

    // Basic capture, trigger on sample 3, post 3.
    do_arm(3);
    chk("arm_state", state, 1);
    for (int k = 1; k <= 6; k++) begin
      samp(k, k == 3);
      if (k == 3) chk("post_state", state, 2);
    end
    chk("basic_state", state, 3);
    chk("basic_done", done, 1);
    chk("basic_count", count, 6);
    chk("basic_tpos", trig_pos, 2);
    chk("basic_wrap", wrapped, 0);
    chk("basic_left", rd_left, 6);
    for (int k = 1; k <= 6; k++) begin
      rd();
      chk("basic_rv", rd_valid, 1);
      chk("basic_rd", rd_data, mk(k));
    end
    tick();
    chk("under_rv0", rd_valid, 0);
    rd();
    rd();
    chk("under_rv", rd_valid, 0);
    chk("under_left", rd_left, 0);
    chk("under_data", rd_data, mk(6));

    // Wrap: 22 samples, trigger on 20, post 2.
    do_arm(2);
    for (int k = 1; k <= 22; k++) samp(k, k == 20);
    chk("wrap_state", state, 3);
    chk("wrap_count", count, 8);
    chk("wrap_flag", wrapped, 1);
    chk("wrap_tpos", trig_pos, 5);
    for (int k = 15; k <= 22; k++) begin
      rd();
      chk("wrap_rd", rd_data, mk(k));
    end

    // Zero post length; trig_in without sample_en ignored.
    do_arm(0);
    trig_in = 1'b1;
    tick();
    trig_in = 1'b0;
    chk("notrig_state", state, 1);
    for (int k = 1; k <= 4; k++) samp(k, k == 4);
    chk("zero_state", state, 3);
    chk("zero_count", count, 4);
    chk("zero_tpos", trig_pos, 3);

    // Oversized post_len saturates to DEPTH-1.
    do_arm(15);
    for (int k = 1; k <= 11; k++) begin
      samp(k, k == 4);
      if (k == 10) chk("sat_post", state, 2);
    end
    chk("sat_state", state, 3);
    chk("sat_tpos", trig_pos, 0);
    rd();
    chk("sat_rd", rd_data, mk(4));

    // Abort mid-POST, arm+abort together, arm while ARMED.
    do_arm(4);
    samp(1, 1'b1);
    chk("ab_post", state, 2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_state", state, 0);
    chk("ab_done", done, 0);
    arm = 1'b1;
    abort = 1'b1;
    tick();
    arm = 1'b0;
    abort = 1'b0;
    chk("armab_state", state, 0);
    do_arm(4);
    samp(1, 1'b0);
    samp(2, 1'b0);
    do_arm(0);
    chk("rearm_count", count, 2);
    chk("rearm_state", state, 1);
    samp(3, 1'b1);
    chk("rearm_post", state, 2);
    samp(4, 1'b0);

    // Asynchronous reset during POST.
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("ar_state", state, 0);
    chk("ar_count", count, 0);
    chk("ar_done", done, 0);
    chk("ar_valid", rd_valid, 0);
    tick();
    tick();
    reset = 1'b0;
    rd();
    tick();
    chk("post_rst_state", state, 0);
    chk("post_rst_valid", rd_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
